// File: rtl/valid_burst_gen.sv
// Gated sample-valid burst generator: one-shot or periodic bursts of clk_en beats with idle gaps.
// Define VALID_BURST_STATS_EN to add the saturating burst_total completed-burst counter output.
module valid_burst_gen #(
   parameter int CNT_W         = 32,
   parameter int AUTO_START    = 1,
   parameter int DEFAULT_LIMIT = 224
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_en,
   input  logic             start,
   input  logic             abort,
   input  logic             cfg_periodic,
   input  logic [CNT_W-1:0] cfg_limit,
   input  logic [CNT_W-1:0] cfg_gap,
   output logic             valid,
   output logic             last,
   output logic             busy,
   output logic             done,
`ifdef VALID_BURST_STATS_EN
   output logic [CNT_W-1:0] beat_cnt,
   output logic [CNT_W-1:0] burst_total
`else
   output logic [CNT_W-1:0] beat_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

   localparam logic [CNT_W-1:0] DEF_LIM = CNT_W'(DEFAULT_LIMIT);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0] limit_q, limit_d;
   logic [CNT_W-1:0] gap_q, gap_d;
   logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             done_q, done_d;
   logic             auto_q;
   logic             enter_run;
   logic             valid_w;
   logic             last_w;
   logic             gap_end;
   logic [CNT_W-1:0] eff_limit;

   assign eff_limit = (cfg_limit == '0) ? DEF_LIM : cfg_limit;
   assign valid_w   = (state_q == RUN) && clk_en && !abort && !reset;
   assign last_w    = valid_w && (beat_cnt_q == limit_q - ONE);
   // A zero latched gap leaves GAP after one cycle instead of waiting for a wrap.
   assign gap_end   = (gap_q == '0) || (gap_cnt_q == gap_q - ONE);

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      limit_d    = limit_q;
      gap_d      = gap_q;
      gap_cnt_d  = gap_cnt_q;
      done_d     = 1'b0;
      enter_run  = 1'b0;
      if (abort) begin
         state_d   = IDLE;
         gap_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start || ((AUTO_START != 0) && auto_q)) begin
                  enter_run = 1'b1;
               end
            end
            RUN: begin
               if (valid_w) begin
                  beat_cnt_d = beat_cnt_q + ONE;
                  if (last_w) begin
                     if (!cfg_periodic) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end else if (gap_q == '0) begin
                        enter_run = 1'b1;
                     end else begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                        limit_d   = eff_limit;
                        gap_d     = cfg_gap;
                     end
                  end
               end
            end
            GAP: begin
               if (gap_end) begin
                  enter_run = 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt_q + ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (enter_run) begin
         state_d    = RUN;
         beat_cnt_d = '0;
         gap_cnt_d  = '0;
         limit_d    = eff_limit;
         gap_d      = cfg_gap;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
         limit_q    <= DEF_LIM;
         gap_q      <= '0;
         gap_cnt_q  <= '0;
         done_q     <= 1'b0;
         auto_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         limit_q    <= limit_d;
         gap_q      <= gap_d;
         gap_cnt_q  <= gap_cnt_d;
         done_q     <= done_d;
         auto_q     <= 1'b0;
      end
   end

   assign valid    = valid_w;
   assign last     = last_w;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign beat_cnt = beat_cnt_q;

`ifdef VALID_BURST_STATS_EN
   logic [CNT_W-1:0] total_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         total_q <= '0;
      end else if (last_w && (total_q != '1)) begin
         total_q <= total_q + ONE;
      end
   end

   assign burst_total = total_q;
`endif

endmodule

// File: tb/tb_valid_burst_gen.sv
// Self-checking bench for valid_burst_gen: directed scenarios plus random traffic against a cycle model.
// Honours VALID_BURST_STATS_EN to also check burst_total.
`timescale 1ns/1ps
module tb_valid_burst_gen;
   localparam int CNT_W   = 32;
   localparam int DEF_LIM = 224;

   logic             clk = 1'b0;
   logic             reset, clk_en, start, abort, cfg_periodic;
   logic [CNT_W-1:0] cfg_limit, cfg_gap;
   logic             valid, last, busy, done;
   logic [CNT_W-1:0] beat_cnt;
`ifdef VALID_BURST_STATS_EN
   logic [CNT_W-1:0] burst_total;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   valid_burst_gen #(.CNT_W(CNT_W), .AUTO_START(1), .DEFAULT_LIMIT(DEF_LIM)) dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .abort(abort),
      .cfg_periodic(cfg_periodic), .cfg_limit(cfg_limit), .cfg_gap(cfg_gap),
      .valid(valid), .last(last), .busy(busy), .done(done),
`ifdef VALID_BURST_STATS_EN
      .beat_cnt(beat_cnt), .burst_total(burst_total)
`else
      .beat_cnt(beat_cnt)
`endif
   );

   // Reference model: phase 0 idle, 1 bursting, 2 waiting out a gap.
   int      m_phase;
   longint  m_cnt, m_lim, m_gap, m_gap_left, m_total;
   bit      m_done, m_auto;
   bit      o_valid, o_last, o_done;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_cnt = 0; m_done = 0; m_auto = 1; m_total = 0;
      m_lim = DEF_LIM; m_gap = 0; m_gap_left = 0;
   endtask

   task automatic enter_run();
      m_phase = 1;
      m_cnt   = 0;
      m_lim   = (cfg_limit == 0) ? DEF_LIM : longint'(cfg_limit);
      m_gap   = longint'(cfg_gap);
   endtask

   // Check outputs mid-cycle, then advance the model across the next rising edge.
   task automatic tick();
      bit ev, el, pend;
      #2;
      ev = !reset && (m_phase == 1) && clk_en && !abort;
      el = ev && (m_cnt + 1 == m_lim);
      chk("valid", valid, ev);
      chk("last", last, el);
      chk("busy", busy, m_phase != 0);
      chk("done", done, m_done);
      chk("beat_cnt", beat_cnt, m_cnt);
`ifdef VALID_BURST_STATS_EN
      chk("burst_total", burst_total, m_total);
`endif
      o_valid = valid; o_last = last; o_done = done;
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else begin
         pend   = m_auto;
         m_auto = 0;
         m_done = 0;
         if (el && m_total != 64'hFFFF_FFFF) m_total++;
         if (abort) begin
            m_phase = 0;
         end else if (m_phase == 0) begin
            if (start || pend) enter_run();
         end else if (m_phase == 1) begin
            if (ev) m_cnt++;
            if (el) begin
               if (!cfg_periodic) begin
                  m_phase = 0;
                  m_done  = 1;
               end else if (m_gap == 0) begin
                  enter_run();
               end else begin
                  m_phase    = 2;
                  m_gap_left = longint'(cfg_gap);
               end
            end
         end else begin
            if (m_gap_left <= 1) enter_run();
            else m_gap_left--;
         end
      end
      #1;
   endtask

   initial begin
      int nv, nl, lidx, nd;
      bit prev_last;
      reset = 1; clk_en = 1; start = 0; abort = 0; cfg_periodic = 0;
      cfg_limit = 0; cfg_gap = 0;
      @(posedge clk);
      model_reset();
      #1;
      tick(); tick();
      #2;
      chk("reset_busy", busy, 0);
      chk("reset_cnt", beat_cnt, 0);
      chk("reset_valid", valid, 0);

      // Legacy: auto start, default limit, clk_en always high
      reset = 0; nv = 0; nl = 0; lidx = 0;
      repeat (260) begin
         tick();
         if (o_valid) nv++;
         if (o_last) begin nl++; lidx = nv; end
      end
      chk("legacy_valid_count", nv, 224);
      chk("legacy_last_count", nl, 1);
      chk("legacy_last_pos", lidx, 224);

      // One-shot with sparse clk_en
      cfg_limit = 5; start = 1; tick(); start = 0;
      nv = 0; lidx = 0; nd = 0; prev_last = 0;
      for (int i = 0; i < 30; i++) begin
         clk_en = i[0];
         tick();
         if (o_done) begin nd++; chk("oneshot_done_after_last", prev_last, 1); end
         prev_last = o_last;
         if (o_valid) nv++;
         if (o_last) lidx = nv;
      end
      chk("oneshot_beats", nv, 5);
      chk("oneshot_last_pos", lidx, 5);
      chk("oneshot_done_count", nd, 1);
      chk("oneshot_idle", busy, 0);

      // Periodic 3 on / 4 off, then gap 0
      clk_en = 1; cfg_limit = 3; cfg_gap = 4; cfg_periodic = 1;
      start = 1; tick(); start = 0;
      nv = 0; nl = 0;
      for (int i = 0; i < 21; i++) begin
         tick();
         chk("periodic_pattern", o_valid, (i % 7) < 3);
         if (o_valid) nv++;
         if (o_last) nl++;
      end
      chk("periodic_valid_count", nv, 9);
      chk("periodic_last_count", nl, 3);
      cfg_gap = 0;
      repeat (7) tick();
      nv = 0; nl = 0;
      repeat (30) begin
         tick();
         if (o_valid) nv++;
         if (o_last) nl++;
      end
      chk("gap0_valid_count", nv, 30);
      chk("gap0_last_count", nl, 10);
      abort = 1; tick(); abort = 0;

      // Abort on beat 2 of 8, with an ignored start mid-burst
      cfg_periodic = 0; cfg_limit = 8;
      start = 1; tick();
      tick(); start = 0;
      tick();
      abort = 1; tick(); abort = 0;
      chk("abort_valid", o_valid, 0);
      #2;
      chk("abort_cnt", beat_cnt, 2);
      chk("abort_busy", busy, 0);
      nd = 0;
      repeat (5) begin tick(); if (o_done) nd++; end
      chk("abort_no_done", nd, 0);

      // Reset at beat 4, then limit change mid-burst
      start = 1; tick(); start = 0;
      repeat (4) tick();
      reset = 1; tick();
      chk("reset_mid_valid", o_valid, 0);
      #2;
      chk("reset_mid_cnt", beat_cnt, 0);
      cfg_limit = 6; reset = 0;
      tick();
      nv = 0;
      repeat (3) begin tick(); if (o_valid) nv++; end
      cfg_limit = 2;
      repeat (10) begin tick(); if (o_valid) nv++; end
      chk("old_limit_used", nv, 6);

      // Three periodic bursts after reset
      reset = 1; tick(); reset = 0;
      cfg_limit = 3; cfg_gap = 2; cfg_periodic = 1;
      nl = 0;
      for (int i = 0; i < 50 && nl < 3; i++) begin
         tick();
         if (o_last) nl++;
      end
      chk("stats_bursts_seen", nl, 3);
      abort = 1; tick(); abort = 0;
`ifdef VALID_BURST_STATS_EN
      #2;
      chk("stats_total", burst_total, 3);
`endif

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset  = ($urandom_range(0, 199) == 0);
         abort  = ($urandom_range(0, 59) == 0);
         start  = ($urandom_range(0, 14) == 0);
         clk_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) cfg_periodic = $urandom_range(0, 1);
         if ($urandom_range(0, 9) == 0)
            cfg_limit = ($urandom_range(0, 49) == 0) ? 0 : $urandom_range(1, 6);
         if ($urandom_range(0, 9) == 0) cfg_gap = $urandom_range(0, 4);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
